// File: rtl/section_meter_pkg.sv
// rtl/section_meter_pkg.sv - shared types and helpers for the section range meter
//
// Contents:
//   state_t     : meter FSM state (ACCUM collects frames, EMIT streams ranges)
//   chan_width  : width of a channel index, never less than one bit

package section_meter_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

    function automatic int chan_width(input int channels);
        return (channels <= 1) ? 1 : $clog2(channels);
    endfunction

endpackage

// File: rtl/range_tracker.sv
// rtl/range_tracker.sv - per-channel running minimum/maximum over a section
//
// Ports:
//   clk          : clock, rising edge
//   reset        : synchronous active-high reset
//   load         : load both min and max with sample (first frame of a section)
//   update       : fold sample into min/max (later frames of a section)
//   sample       : channel sample, signed or unsigned per SIGNED
//   range_value  : max - min of the registered state
//   range_next   : max - min as it will be after this cycle's load/update

module range_tracker #(
    parameter int WIDTH  = 16,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             update,
    input  logic [WIDTH-1:0] sample,
    output logic [WIDTH-1:0] range_value,
    output logic [WIDTH-1:0] range_next
);

    logic [WIDTH-1:0] min_q;
    logic [WIDTH-1:0] max_q;
    logic [WIDTH-1:0] min_d;
    logic [WIDTH-1:0] max_d;
    logic             above_max;
    logic             below_min;

    always_comb begin
        if (SIGNED != 0) begin
            above_max = $signed(sample) > $signed(max_q);
            below_min = $signed(sample) < $signed(min_q);
        end else begin
            above_max = sample > max_q;
            below_min = sample < min_q;
        end
    end

    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (load) begin
            min_d = sample;
            max_d = sample;
        end else if (update) begin
            if (above_max) max_d = sample;
            if (below_min) min_d = sample;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            min_q <= '0;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    // The true range never exceeds 2^WIDTH-1, so a modulo-2^WIDTH difference
    // is exact for both signed and unsigned samples.
    assign range_value = max_q - min_q;
    assign range_next  = max_d - min_d;

endmodule

// File: rtl/section_range_meter.sv
// rtl/section_range_meter.sv - multi-channel section peak-to-peak meter
//
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   i_valid    : input frame valid
//   i_ready    : frame accepted when i_valid && i_ready (registered, state only)
//   i_value    : frame, channel n in bits [n*WIDTH +: WIDTH]
//   o_valid    : output word valid
//   o_ready    : output word consumed when o_valid && o_ready
//   o_value    : unsigned max - min for o_channel
//   o_channel  : channel index of o_value
//   o_last     : marks the final channel word of a section

module section_range_meter
    import section_meter_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int CHANNELS     = 2,
    parameter int SAMPLE_COUNT = 735,
    parameter int SIGNED       = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_valid,
    output logic                            i_ready,
    input  logic [CHANNELS*WIDTH-1:0]       i_value,
    output logic                            o_valid,
    input  logic                            o_ready,
    output logic [WIDTH-1:0]                o_value,
    output logic [chan_width(CHANNELS)-1:0] o_channel,
    output logic                            o_last
);

    localparam int CW    = chan_width(CHANNELS);
    localparam int CNTW  = $clog2(SAMPLE_COUNT + 1);
    localparam int NSLOT = 1 << CW;

    state_t            state;
    logic [CNTW-1:0]   count;
    logic [CW-1:0]     emit_idx;
    logic [CW-1:0]     next_idx;
    logic              accept;
    logic              first_frame;
    logic              last_frame;
    logic              next_is_last;

    // Ranges indexed by a full CW-bit index; slots beyond CHANNELS read zero.
    logic [WIDTH-1:0]  range_cur  [NSLOT];
    logic [WIDTH-1:0]  range_new  [CHANNELS];

    always_comb begin
        accept       = i_valid && i_ready;
        first_frame  = (count == '0);
        last_frame   = (count == CNTW'(SAMPLE_COUNT - 1));
        next_idx     = emit_idx + 1'b1;
        next_is_last = (next_idx == CW'(CHANNELS - 1));
    end

    genvar ch;
    generate
        for (ch = 0; ch < CHANNELS; ch++) begin : gen_track
            range_tracker #(
                .WIDTH  (WIDTH),
                .SIGNED (SIGNED)
            ) u_track (
                .clk         (clk),
                .reset       (reset),
                .load        (accept && first_frame),
                .update      (accept && !first_frame),
                .sample      (i_value[ch*WIDTH +: WIDTH]),
                .range_value (range_cur[ch]),
                .range_next  (range_new[ch])
            );
        end
        for (ch = CHANNELS; ch < NSLOT; ch++) begin : gen_pad
            assign range_cur[ch] = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ACCUM;
            count     <= '0;
            emit_idx  <= '0;
            i_ready   <= 1'b1;
            o_valid   <= 1'b0;
            o_value   <= '0;
            o_channel <= '0;
            o_last    <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (last_frame) begin
                            // Channel 0's range must include the frame being
                            // accepted now, so it comes from the tracker's
                            // next-state value rather than its registers.
                            count     <= '0;
                            state     <= EMIT;
                            i_ready   <= 1'b0;
                            emit_idx  <= '0;
                            o_valid   <= 1'b1;
                            o_channel <= '0;
                            o_value   <= range_new[0];
                            o_last    <= (CHANNELS == 1);
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (o_valid && o_ready) begin
                        if (o_last) begin
                            state   <= ACCUM;
                            i_ready <= 1'b1;
                            o_valid <= 1'b0;
                            o_last  <= 1'b0;
                        end else begin
                            emit_idx  <= next_idx;
                            o_channel <= next_idx;
                            o_value   <= range_cur[next_idx];
                            o_last    <= next_is_last;
                        end
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_section_range_meter.sv
// tb/tb_section_range_meter.sv - self-checking bench for section_range_meter

module tb_section_range_meter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A: 2 channels, 4-frame sections, unsigned
    logic        a_reset, a_i_valid, a_i_ready, a_o_valid, a_o_ready, a_o_last;
    logic [31:0] a_i_value;
    logic [15:0] a_o_value;
    logic [0:0]  a_o_channel;

    // Instance B: 1 channel, 2-frame sections, signed
    logic        b_reset, b_i_valid, b_i_ready, b_o_valid, b_o_ready, b_o_last;
    logic [15:0] b_i_value;
    logic [15:0] b_o_value;
    logic [0:0]  b_o_channel;

    // Instance C: 3 channels, 1-frame sections, unsigned
    logic        c_reset, c_i_valid, c_i_ready, c_o_valid, c_o_ready, c_o_last;
    logic [47:0] c_i_value;
    logic [15:0] c_o_value;
    logic [1:0]  c_o_channel;

    section_range_meter #(.WIDTH(16), .CHANNELS(2), .SAMPLE_COUNT(4), .SIGNED(0)) dut_a (
        .clk(clk), .reset(a_reset), .i_valid(a_i_valid), .i_ready(a_i_ready),
        .i_value(a_i_value), .o_valid(a_o_valid), .o_ready(a_o_ready),
        .o_value(a_o_value), .o_channel(a_o_channel), .o_last(a_o_last));

    section_range_meter #(.WIDTH(16), .CHANNELS(1), .SAMPLE_COUNT(2), .SIGNED(1)) dut_b (
        .clk(clk), .reset(b_reset), .i_valid(b_i_valid), .i_ready(b_i_ready),
        .i_value(b_i_value), .o_valid(b_o_valid), .o_ready(b_o_ready),
        .o_value(b_o_value), .o_channel(b_o_channel), .o_last(b_o_last));

    section_range_meter #(.WIDTH(16), .CHANNELS(3), .SAMPLE_COUNT(1), .SIGNED(0)) dut_c (
        .clk(clk), .reset(c_reset), .i_valid(c_i_valid), .i_ready(c_i_ready),
        .i_value(c_i_value), .o_valid(c_o_valid), .o_ready(c_o_ready),
        .o_value(c_o_value), .o_channel(c_o_channel), .o_last(c_o_last));

    typedef struct packed {
        logic [3:0][15:0] s0;
        logic [3:0][15:0] s1;
        logic [15:0]      r0;
        logic [15:0]      r1;
    } a_vec_t;

    typedef struct packed {
        logic [15:0] s0;
        logic [15:0] s1;
        logic [15:0] r;
    } b_vec_t;

    typedef struct {
        int          ch;
        logic [15:0] val;
        logic        last;
    } word_t;

    a_vec_t a_tab [4];
    b_vec_t b_tab [4];
    word_t  exp_q [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Plain min/max over a section, independent of how the DUT tracks it.
    function automatic logic [15:0] span4(input logic [3:0][15:0] v);
        int mn, mx;
        mn = v[0];
        mx = v[0];
        for (int i = 1; i < 4; i++) begin
            if (int'(v[i]) < mn) mn = v[i];
            if (int'(v[i]) > mx) mx = v[i];
        end
        return 16'(mx - mn);
    endfunction

    task automatic a_feed(input logic [3:0][15:0] s0, input logic [3:0][15:0] s1);
        for (int i = 0; i < 4; i++) begin
            check("a_feed_i_ready", a_i_ready, 1);
            a_i_valid = 1'b1;
            a_i_value = {s1[i], s0[i]};
            step();
        end
        a_i_valid = 1'b0;
    endtask

    task automatic a_word(input int ch, input logic [15:0] val, input logic last);
        check("a_o_valid", a_o_valid, 1);
        check("a_o_channel", a_o_channel, ch);
        check("a_o_value", a_o_value, val);
        check("a_o_last", a_o_last, last);
        check("a_i_ready_emit", a_i_ready, 0);
    endtask

    task automatic a_section(input a_vec_t v);
        a_o_ready = 1'b1;
        a_feed(v.s0, v.s1);
        a_word(0, v.r0, 1'b0);
        step();
        a_word(1, v.r1, 1'b1);
        step();
        check("a_i_ready_after", a_i_ready, 1);
        check("a_o_valid_after", a_o_valid, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal;
    end

    initial begin
        a_tab[0].s0 = {16'd10, 16'd50, 16'd20, 16'd30};
        a_tab[0].s1 = {16'd7, 16'd7, 16'd7, 16'd7};
        a_tab[0].r0 = 16'd40;    a_tab[0].r1 = 16'd0;
        a_tab[1].s0 = {16'd0, 16'd65535, 16'd1, 16'd2};
        a_tab[1].s1 = {16'd100, 16'd3, 16'd200, 16'd50};
        a_tab[1].r0 = 16'd65535; a_tab[1].r1 = 16'd197;
        a_tab[2].s0 = {16'd5, 16'd5, 16'd5, 16'd5};
        a_tab[2].s1 = {16'd9, 16'd8, 16'd7, 16'd6};
        a_tab[2].r0 = 16'd0;     a_tab[2].r1 = 16'd3;
        a_tab[3].s0 = {16'd1000, 16'd999, 16'd1001, 16'd1000};
        a_tab[3].s1 = {16'd65535, 16'd65535, 16'd65534, 16'd65535};
        a_tab[3].r0 = 16'd2;     a_tab[3].r1 = 16'd1;

        b_tab[0] = '{s0: 16'h8000, s1: 16'h7fff, r: 16'd65535};
        b_tab[1] = '{s0: 16'hfffb, s1: 16'hffff, r: 16'd4};
        b_tab[2] = '{s0: 16'h0003, s1: 16'hfffe, r: 16'd5};
        b_tab[3] = '{s0: 16'hff9c, s1: 16'hff9c, r: 16'd0};

        a_reset = 1'b1; a_i_valid = 1'b0; a_i_value = '0; a_o_ready = 1'b1;
        b_reset = 1'b1; b_i_valid = 1'b0; b_i_value = '0; b_o_ready = 1'b1;
        c_reset = 1'b1; c_i_valid = 1'b0; c_i_value = '0; c_o_ready = 1'b1;
        step();
        step();
        a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;

        // Reset state
        check("rst_a_o_valid", a_o_valid, 0);
        check("rst_a_o_value", a_o_value, 0);
        check("rst_a_o_channel", a_o_channel, 0);
        check("rst_a_o_last", a_o_last, 0);
        check("rst_a_i_ready", a_i_ready, 1);
        check("rst_b_i_ready", b_i_ready, 1);
        check("rst_c_o_valid", c_o_valid, 0);

        // Table-driven unsigned sections
        for (int t = 0; t < 4; t++) a_section(a_tab[t]);

        // Backpressure for 5 cycles during EMIT, then a clean next section
        a_o_ready = 1'b0;
        a_feed({16'd100, 16'd900, 16'd500, 16'd300}, {16'd0, 16'd1, 16'd2, 16'd3});
        for (int i = 0; i < 5; i++) begin
            a_word(0, 16'd800, 1'b0);
            step();
        end
        a_o_ready = 1'b1;
        a_word(0, 16'd800, 1'b0);
        step();
        a_word(1, 16'd3, 1'b1);
        step();
        check("bp_i_ready_after", a_i_ready, 1);
        a_section(a_tab[2]);

        // Reset mid-section: the two pre-reset frames must be excluded
        a_i_valid = 1'b1;
        a_i_value = {16'd0, 16'd60000};
        step();
        a_i_value = {16'd60000, 16'd1};
        step();
        a_i_valid = 1'b0;
        a_reset = 1'b1;
        step();
        a_reset = 1'b0;
        check("midrst_o_valid", a_o_valid, 0);
        check("midrst_i_ready", a_i_ready, 1);
        a_section(a_tab[0]);

        // Reset during EMIT
        a_o_ready = 1'b0;
        a_feed(a_tab[3].s0, a_tab[3].s1);
        check("emitrst_pre_valid", a_o_valid, 1);
        a_reset = 1'b1;
        step();
        a_reset = 1'b0;
        check("emitrst_o_valid", a_o_valid, 0);
        check("emitrst_i_ready", a_i_ready, 1);
        check("emitrst_o_last", a_o_last, 0);
        check("emitrst_o_channel", a_o_channel, 0);
        check("emitrst_o_value", a_o_value, 0);
        a_section(a_tab[1]);

        // Signed sections
        for (int t = 0; t < 4; t++) begin
            check("b_i_ready0", b_i_ready, 1);
            b_i_valid = 1'b1;
            b_i_value = b_tab[t].s0;
            step();
            check("b_i_ready1", b_i_ready, 1);
            b_i_value = b_tab[t].s1;
            step();
            b_i_valid = 1'b0;
            check("b_o_valid", b_o_valid, 1);
            check("b_o_channel", b_o_channel, 0);
            check("b_o_value", b_o_value, b_tab[t].r);
            check("b_o_last", b_o_last, 1);
            step();
            check("b_i_ready_after", b_i_ready, 1);
            check("b_o_valid_after", b_o_valid, 0);
        end

        // SAMPLE_COUNT=1 with three channels, input held valid throughout
        c_i_valid = 1'b1;
        for (int f = 0; f < 5; f++) begin
            c_i_value = {16'($urandom), 16'($urandom), 16'($urandom)};
            check("c_i_ready", c_i_ready, 1);
            step();
            for (int k = 0; k < 3; k++) begin
                check("c_o_valid", c_o_valid, 1);
                check("c_o_channel", c_o_channel, k);
                check("c_o_value", c_o_value, 0);
                check("c_o_last", c_o_last, (k == 2));
                check("c_i_ready_emit", c_i_ready, 0);
                step();
            end
        end
        c_i_valid = 1'b0;

        // Randomized gapped input and output backpressure vs reference model
        begin
            logic [3:0][15:0] fr0, fr1;
            int nf, sect;
            word_t w;
            nf = 0;
            sect = 0;
            for (int cyc = 0; cyc < 8000 && sect < 100; cyc++) begin
                a_i_valid = ($urandom_range(0, 1) == 1);
                if ($urandom_range(0, 3) == 0)
                    a_i_value = {16'($urandom_range(0, 7)), 16'($urandom_range(0, 7))};
                else
                    a_i_value = {16'($urandom), 16'($urandom)};
                a_o_ready = ($urandom_range(0, 3) != 0);
                if (a_o_valid && a_o_ready) begin
                    if (exp_q.size() == 0) begin
                        check("rnd_unexpected_word", a_o_valid, 0);
                    end else begin
                        w = exp_q.pop_front();
                        check("rnd_o_channel", a_o_channel, w.ch);
                        check("rnd_o_value", a_o_value, w.val);
                        check("rnd_o_last", a_o_last, w.last);
                        if (w.last) sect++;
                    end
                end
                if (a_i_valid && a_i_ready) begin
                    fr0[nf] = a_i_value[15:0];
                    fr1[nf] = a_i_value[31:16];
                    nf++;
                    if (nf == 4) begin
                        exp_q.push_back('{ch: 0, val: span4(fr0), last: 1'b0});
                        exp_q.push_back('{ch: 1, val: span4(fr1), last: 1'b1});
                        nf = 0;
                    end
                end
                step();
            end
            a_i_valid = 1'b0;
            check("rnd_sections_done", sect, 100);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/section_range_meter.md
# section_range_meter

Multi-channel section peak-to-peak meter for the audio level meter path. Accepts parallel PCM frames (one sample per channel) and tracks per-channel minimum and maximum over a fixed section of SAMPLE_COUNT frames. At section end it emits one range value (max − min) per channel as a sequential stream, with backpressure. It sits between the sample source and the display/level-mapping stage, and supersedes the single-channel unsigned section difference block.

## Interface
- WIDTH, 16: sample width per channel.
- CHANNELS, 2: channel count, ≥1.
- SAMPLE_COUNT, 735: frames per section (60 fps at 44.1 kHz), ≥1.
- SIGNED, 0: 1 = samples are two's complement; 0 = unsigned.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_valid  in  1  input frame valid.
- i_ready  out  1  frame accepted when i_valid && i_ready.
- i_value  in  CHANNELS*WIDTH  frame; channel n in bits [n*WIDTH +: WIDTH].
- o_valid  out  1  output word valid.
- o_ready  in  1  output word consumed when o_valid && o_ready.
- o_value  out  WIDTH  unsigned range max − min for o_channel.
- o_channel  out  max(1,$clog2(CHANNELS))  channel index of o_value.
- o_last  out  1  high on the final (CHANNELS−1) word of a section.

## Operation
- Two states: ACCUM and EMIT. Reset state: ACCUM, frame count 0, emit index 0.
- Reset values: o_valid=0, o_value=0, o_channel=0, o_last=0, i_ready=1.
- ACCUM: i_ready=1, o_valid=0. Each accepted frame updates every channel:
  - If it is the first frame of the section (count 0), it loads both min and max with the sample.
  - Otherwise max ← sample if sample > max, and min ← sample if sample < min.
  - Comparisons are signed when SIGNED=1 and unsigned otherwise.
  - Count increments on each accepted frame.
- Accepting frame number SAMPLE_COUNT (count == SAMPLE_COUNT−1) includes that frame in the min/max update. Count then returns to 0 and the state goes to EMIT.
- A section is exactly SAMPLE_COUNT frames and no frame is dropped.
- EMIT: i_ready=0, so input is stalled. The block presents channels 0..CHANNELS−1 in order:
  - o_value = max − min, computed at WIDTH+1 bits and truncated to WIDTH. This is exact in both modes because the range is ≤ 2^WIDTH − 1.
  - o_channel and o_last hold stable while o_valid && !o_ready.
- On the handshake of the o_last word, the state returns to ACCUM. The next section's first frame reloads min/max, so no explicit clear is needed.
- Reset asserted in any state (mid-section or mid-EMIT) forces the reset values on the next edge. The partial section is discarded and pending output words are lost.

## Timing
- Frame t is the last of its section → o_valid=1 with o_channel=0 on cycle t+1. o_value is registered, with no combinational path from i_value.
- One word per cycle while o_ready=1. An unstalled EMIT lasts CHANNELS cycles.
- i_ready is high again on the cycle after the o_last handshake. A frame can then be accepted that cycle.
- Worst-case input stall is CHANNELS cycles per section plus any o_ready stall.
- SAMPLE_COUNT=1: every accepted frame triggers EMIT with range 0 on all channels.
- i_ready depends only on state. There is no combinational path from i_valid or o_ready to i_ready.
- The count register is $clog2(SAMPLE_COUNT+1) bits wide and never exceeds SAMPLE_COUNT−1.

## Structure
- Package section_meter_pkg holds:
  - the state enum (ACCUM, EMIT);
  - a function computing the channel-index width, max(1,$clog2(CHANNELS)).
- Sub-module range_tracker (parameters WIDTH, SIGNED) holds one channel's min/max registers with load/update inputs.
- The top level generates CHANNELS instances of range_tracker and owns the count, the FSM, the emit index and the output mux/subtract.

## Test plan
- WIDTH=16, CHANNELS=2, SAMPLE_COUNT=4, unsigned:
  - Stimulus: ch0 {10,50,20,30}, ch1 {7,7,7,7}, o_ready=1.
  - Required: words (ch0, 40, last=0) then (ch1, 0, last=1). Output starts the cycle after the 4th frame. i_ready=0 for exactly 2 cycles.
- SIGNED=1, WIDTH=16, SAMPLE_COUNT=2:
  - Stimulus: ch0 {−32768, 32767}.
  - Required: o_value=65535 for ch0. Also ch0 {−5,−1} → 4.
- Backpressure:
  - Stimulus: hold o_ready=0 for 5 cycles during EMIT.
  - Required: o_valid, o_value, o_channel and o_last stay stable and i_ready stays 0. The next section then starts clean: its first frame reloads and the prior min/max have no effect.
- SAMPLE_COUNT=1, CHANNELS=3:
  - Stimulus: stream frames continuously.
  - Required: every frame yields 3 words of 0. o_last is set on channel 2 only.
- Reset mid-section:
  - Stimulus: 2 of 4 frames accepted, then reset for 1 cycle.
  - Required: the next 4 frames form a full section and the pre-reset samples are excluded.
  - Stimulus: reset during EMIT.
  - Required: o_valid=0 next cycle and i_ready=1.
- Gapped input:
  - Stimulus: i_valid toggled randomly.
  - Required: the section boundary counts only accepted frames. The result matches the reference model over 100 random sections.
